kftvga_text_fetch: RTL and testbench
====================================

KFTVGA_TEXT_FETCH -- requirements
Module: kftvga_text_fetch

Interface
REQ-001 Parameter COLUMNS, 80, character cells per text row.
REQ-002 Parameter ROWS, 25, text rows per frame.
REQ-003 Parameter CHAR_HEIGHT, 16, scanlines per text row.
REQ-004 Parameter FIFO_DEPTH, 4, output cell FIFO entries (power of two, >=2).
REQ-005 Parameter READ_LATENCY, 2, cycles from video_address to valid video_data_in.
REQ-006 clock  in  1  single clock; all logic on rising edge; drives VRAM video port clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 frame_start  in  1  one-cycle pulse; start of new frame.
REQ-009 line_start  in  1  one-cycle pulse; fetch next scanline's cells.
REQ-010 start_address  in  13  VRAM word address of row 0 col 0; sampled on frame_start.
REQ-011 video_address  out  13  VRAM video-port word address.
REQ-012 video_data_in  in  16  VRAM word: [7:0] character code, [15:8] attribute.
REQ-013 cell_valid  out  1  output cell available.
REQ-014 cell_ready  in  1  downstream accepts cell when cell_valid&cell_ready.
REQ-015 cell_code  out  8  character code of head cell.
REQ-016 cell_attribute  out  8  attribute of head cell.
REQ-017 cell_scanline  out  4  scanline within character (0..CHAR_HEIGHT-1) of head cell.
REQ-018 cell_last  out  1  head cell is column COLUMNS-1.
REQ-019 line_overrun  out  1  one-cycle pulse: line_start arrived while a line was still in progress.

Function
REQ-020 FSM states: IDLE, FETCH, DRAIN, DONE.
REQ-021 Line counter L (0..ROWS*CHAR_HEIGHT) = next scanline to fetch; row R=L/CHAR_HEIGHT, scanline S=L%CHAR_HEIGHT.
REQ-022 frame_start: latch start_address, L<=0, flush FIFO, discard in-flight reads, state<=IDLE; no line_overrun.
REQ-023 frame_start and line_start same cycle: frame_start applied first, then line 0 fetch starts that cycle.
REQ-024 line_start in IDLE with L<ROWS*CHAR_HEIGHT: row base = start_address + R*COLUMNS, modulo 8192; column C<=0; state<=FETCH.
REQ-025 FETCH issues one read per cycle at address (base+C) mod 8192 only when FIFO occupancy + in-flight reads < FIFO_DEPTH.
REQ-026 After read of C=COLUMNS-1 issued: state<=DRAIN; DRAIN->IDLE when in-flight count 0; L increments on that transition.
REQ-027 IDLE with L=ROWS*CHAR_HEIGHT: state<=DONE; line_start in DONE ignored until frame_start.
REQ-028 Returned data pushed into FIFO exactly READ_LATENCY cycles after issue, in issue order, tagged with S and last flag.
REQ-029 line_start in FETCH or DRAIN: pulse line_overrun, flush FIFO, discard in-flight, L increments, new line starts as REQ-024.
REQ-030 FIFO never overflows; simultaneous push and pop at full or empty both succeed.
REQ-031 cell_valid rises no earlier than READ_LATENCY+1 cycles after line_start; outputs are registered FIFO head.
REQ-032 video_address holds last issued value when not reading.

Reset
REQ-033 Reset: state IDLE, L=0, latched address 0, FIFO empty, in-flight cleared.
REQ-034 Reset values: video_address 0, cell_valid 0, cell_code 0, cell_attribute 0, cell_scanline 0, cell_last 0, line_overrun 0.
REQ-035 Reset mid-line discards all pending data; no cell emitted until next frame_start/line_start sequence.

Structure
REQ-036 Shared package kftvga_pkg holds fetch-state enum, cell struct (code, attribute, scanline, last), default geometry constants.
REQ-037 One sub-module kftvga_cell_fifo (synchronous FIFO, FIFO_DEPTH entries, valid/ready pop).
REQ-038 In-flight tracking is a READ_LATENCY-deep valid shift register plus counter; no combinational path from cell_ready to video_address.

Verification
REQ-039 start_address=0, frame_start, line_start, cell_ready=1 -> addresses 0..79, 80 cells, cell_last only on 80th, scanline 0.
REQ-040 start_address=0x1FF0, 17th line_start (R=1,S=0) -> addresses wrap 0x0040..0x008F.
REQ-041 cell_ready=0 -> exactly FIFO_DEPTH reads issued, then stalls; release -> all 80 cells in order, none lost.
REQ-042 line_start 10 cycles after previous -> line_overrun pulse, FIFO flushed, next line's cells start at column 0.
REQ-043 400 lines fetched -> 401st line_start ignored (DONE); frame_start+line_start together -> line 0 refetched.
REQ-044 reset asserted mid-FETCH -> all outputs 0 next cycle, cell_valid stays 0 until new line_start.

Source files
------------

// File: rtl/kftvga_pkg.sv
// kftvga text fetch shared types
// fetch state enum, cell bundle, default geometry
package kftvga_pkg;

  localparam int DEF_COLUMNS      = 80;
  localparam int DEF_ROWS         = 25;
  localparam int DEF_CHAR_HEIGHT  = 16;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_READ_LATENCY = 2;
  localparam int ADDR_W           = 13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } fetch_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] attribute;
    logic [3:0] scanline;
    logic       last;
  } cell_t;

endpackage

// File: rtl/kftvga_cell_fifo.sv
// kftvga cell fifo: sync FIFO, registered head, flush
// ports: clock, reset, flush, push/push_cell, pop_ready, head_valid/head_cell, count
module kftvga_cell_fifo
  import kftvga_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  cell_t                      push_cell,
  input  logic                       pop_ready,
  output logic                       head_valid,
  output cell_t                      head_cell,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  cell_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           pop;
  logic           push_ok;

  assign head_valid = (count != '0);
  assign head_cell  = mem[rd_ptr];
  assign pop        = head_valid && pop_ready;
  // a full FIFO still takes a push when the head leaves the same cycle
  assign push_ok    = push && ((count != CW'(DEPTH)) || pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_cell;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

endmodule

// File: rtl/kftvga_text_fetch.sv
// kftvga text fetch: reads one scanline of text cells from VRAM
// ports: clock, reset, frame_start, line_start, start_address,
//   video_address, video_data_in, cell_* stream, line_overrun
module kftvga_text_fetch
  import kftvga_pkg::*;
#(
  parameter int COLUMNS      = DEF_COLUMNS,
  parameter int ROWS         = DEF_ROWS,
  parameter int CHAR_HEIGHT  = DEF_CHAR_HEIGHT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic [12:0] start_address,
  output logic [12:0] video_address,
  input  logic [15:0] video_data_in,
  output logic        cell_valid,
  input  logic        cell_ready,
  output logic [7:0]  cell_code,
  output logic [7:0]  cell_attribute,
  output logic [3:0]  cell_scanline,
  output logic        cell_last,
  output logic        line_overrun
);

  localparam int COL_W = $clog2(COLUMNS);
  localparam int ROW_W = $clog2(ROWS + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int RL    = READ_LATENCY;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLUMNS - 1);
  localparam logic [ROW_W-1:0] ROW_END   = ROW_W'(ROWS);
  localparam logic [3:0]       SCAN_LAST = 4'(CHAR_HEIGHT - 1);
  localparam logic [12:0]      STRIDE    = 13'(COLUMNS);

  fetch_state_t     state;
  logic [12:0]      row_addr_q;
  logic [ROW_W-1:0] row_q;
  logic [3:0]       scan_q;
  logic [COL_W-1:0] col_q;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] fifo_count;
  logic             issue_q;
  logic             issue_last_q;
  logic [RL-1:0]    pipe_v;
  logic [RL-1:0]    pipe_last;

  logic             busy;
  logic             overrun;
  logic             flush;
  logic             room;
  logic             issue;
  logic             scan_wrap;
  logic [3:0]       nxt_scan;
  logic [ROW_W-1:0] nxt_row;
  logic [12:0]      nxt_row_addr;
  cell_t            push_cell;
  cell_t            head_cell;

  assign busy    = (state == ST_FETCH) || (state == ST_DRAIN);
  assign overrun = line_start && !frame_start && busy;
  assign flush   = frame_start || overrun;
  // only registered counts gate issue: cell_ready never reaches the address
  assign room    = ({1'b0, fifo_count} + {1'b0, inflight_q})
                 < SUM_W'(FIFO_DEPTH);
  assign issue   = (state == ST_FETCH) && !flush && room;

  assign scan_wrap    = (scan_q == SCAN_LAST);
  assign nxt_scan     = scan_wrap ? 4'd0 : scan_q + 4'd1;
  assign nxt_row      = scan_wrap ? row_q + ROW_W'(1) : row_q;
  assign nxt_row_addr = scan_wrap ? row_addr_q + STRIDE : row_addr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      row_addr_q    <= '0;
      row_q         <= '0;
      scan_q        <= '0;
      col_q         <= '0;
      video_address <= '0;
      line_overrun  <= 1'b0;
    end else begin
      line_overrun <= overrun;
      if (issue) video_address <= row_addr_q + 13'(col_q);
      if (frame_start) begin
        row_addr_q <= start_address;
        row_q      <= '0;
        scan_q     <= '0;
        col_q      <= '0;
        state      <= line_start ? ST_FETCH : ST_IDLE;
      end else if (overrun) begin
        row_addr_q <= nxt_row_addr;
        row_q      <= nxt_row;
        scan_q     <= nxt_scan;
        col_q      <= '0;
        state      <= (nxt_row == ROW_END) ? ST_IDLE : ST_FETCH;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (row_q == ROW_END) begin
              state <= ST_DONE;
            end else if (line_start) begin
              col_q <= '0;
              state <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (issue) begin
              col_q <= col_q + COL_W'(1);
              if (col_q == COL_LAST) state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (inflight_q == '0) begin
              row_addr_q <= nxt_row_addr;
              row_q      <= nxt_row;
              scan_q     <= nxt_scan;
              state      <= ST_IDLE;
            end
          end
          ST_DONE: state <= ST_DONE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // issue_q marks the cycle the new address is on the bus;
  // pipe_v[RL-1] marks the cycle its data is on video_data_in
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_q      <= 1'b0;
      issue_last_q <= 1'b0;
      pipe_v       <= '0;
      pipe_last    <= '0;
      inflight_q   <= '0;
    end else if (flush) begin
      issue_q      <= 1'b0;
      issue_last_q <= 1'b0;
      pipe_v       <= '0;
      pipe_last    <= '0;
      inflight_q   <= '0;
    end else begin
      issue_q      <= issue;
      issue_last_q <= (col_q == COL_LAST);
      pipe_v[0]    <= issue_q;
      pipe_last[0] <= issue_last_q;
      for (int i = 1; i < RL; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      inflight_q <= inflight_q + CNT_W'(issue)
                  - CNT_W'(pipe_v[RL-1]);
    end
  end

  assign push_cell = '{
    code:      video_data_in[7:0],
    attribute: video_data_in[15:8],
    scanline:  scan_q,
    last:      pipe_last[RL-1]
  };

  kftvga_cell_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .push       (pipe_v[RL-1]),
    .push_cell  (push_cell),
    .pop_ready  (cell_ready),
    .head_valid (cell_valid),
    .head_cell  (head_cell),
    .count      (fifo_count)
  );

  assign cell_code      = head_cell.code;
  assign cell_attribute = head_cell.attribute;
  assign cell_scanline  = head_cell.scanline;
  assign cell_last      = head_cell.last;

endmodule

// File: tb/tb_kftvga_text_fetch.sv
// kftvga text fetch bench: VRAM model, cell scoreboard, directed lines
// compares every accepted cell and line_overrun against a line model
module tb_kftvga_text_fetch;
  import kftvga_pkg::*;

  localparam int RL = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        line_start;
  logic [12:0] start_address;
  logic [12:0] video_address;
  logic [15:0] video_data_in;
  logic        cell_valid;
  logic        cell_ready;
  logic [7:0]  cell_code;
  logic [7:0]  cell_attribute;
  logic [3:0]  cell_scanline;
  logic        cell_last;
  logic        line_overrun;

  always #5 clock = ~clock;

  kftvga_text_fetch #(
    .COLUMNS(80), .ROWS(25), .CHAR_HEIGHT(16),
    .FIFO_DEPTH(4), .READ_LATENCY(RL)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .frame_start    (frame_start),
    .line_start     (line_start),
    .start_address  (start_address),
    .video_address  (video_address),
    .video_data_in  (video_data_in),
    .cell_valid     (cell_valid),
    .cell_ready     (cell_ready),
    .cell_code      (cell_code),
    .cell_attribute (cell_attribute),
    .cell_scanline  (cell_scanline),
    .cell_last      (cell_last),
    .line_overrun   (line_overrun)
  );

  function automatic logic [15:0] vram(input logic [12:0] a);
    return {3'b101, a} ^ 16'h2C5A;
  endfunction

  // VRAM: data for an address appears RL cycles after it is driven
  logic [12:0] hist [RL];
  always @(posedge clock) begin
    hist[0] <= video_address;
    for (int i = 1; i < RL; i++) hist[i] <= hist[i-1];
  end
  assign video_data_in = vram(hist[RL-1]);

  cell_t       exp_q[$];
  cell_t       seen[$];
  logic [12:0] addr_log[$];
  logic [12:0] log_last;
  logic [12:0] mstart;
  int          nl;
  bit          exp_ovr;
  int          ovr_hi;
  int          checks;
  int          errors;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic void add_line(input int n);
    int r;
    int s;
    r = n / 16;
    s = n % 16;
    for (int c = 0; c < 80; c++) begin
      logic [12:0] a;
      logic [15:0] w;
      cell_t e;
      a = 13'((int'(mstart) + r * 80 + c) % 8192);
      w = vram(a);
      e.code      = w[7:0];
      e.attribute = w[15:8];
      e.scanline  = 4'(s);
      e.last      = (c == 79);
      exp_q.push_back(e);
    end
  endfunction

  // compare process
  initial begin
    cell_t got;
    cell_t e;
    forever begin
      @(negedge clock);
      chk("line_overrun", 32'(line_overrun), 32'(exp_ovr));
      if (line_overrun) ovr_hi++;
      if (video_address != log_last) begin
        addr_log.push_back(video_address);
        log_last = video_address;
      end
      if (cell_valid && cell_ready) begin
        got.code      = cell_code;
        got.attribute = cell_attribute;
        got.scanline  = cell_scanline;
        got.last      = cell_last;
        seen.push_back(got);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_cell: got %0h required none", got);
        end else begin
          e = exp_q.pop_front();
          chk("cell", 32'(got), 32'(e));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input bit fs, input bit ls,
                       input logic [12:0] sa, input bit ovr);
    start_address = sa;
    frame_start   = fs;
    line_start    = ls;
    @(posedge clock);
    #1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    if (fs) begin
      exp_q.delete();
      nl     = 0;
      mstart = sa;
    end
    if (ls) begin
      if (ovr) exp_q.delete();
      if (nl < 400) begin
        add_line(nl);
        nl++;
      end
    end
    exp_ovr = ovr;
    tick(1);
    exp_ovr = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    chk({nm, "_left"}, 32'(exp_q.size()), 0);
    exp_q.delete();
    tick(4);
  endtask

  task automatic log_reset();
    addr_log.delete();
    log_last = video_address;
  endtask

  function automatic logic [31:0] log_tail();
    return (addr_log.size() > 0) ? 32'(addr_log[$]) : 32'hFFFF;
  endfunction

  function automatic logic [31:0] seen_at(input int i);
    return (seen.size() > i) ? 32'(seen[i]) : 32'hFFFFFFFF;
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_addr"}, 32'(video_address), 0);
    chk({nm, "_valid"}, 32'(cell_valid), 0);
    chk({nm, "_code"}, 32'(cell_code), 0);
    chk({nm, "_attr"}, 32'(cell_attribute), 0);
    chk({nm, "_scan"}, 32'(cell_scanline), 0);
    chk({nm, "_last"}, 32'(cell_last), 0);
    chk({nm, "_ovr"}, 32'(line_overrun), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lasts;
    checks        = 0;
    errors        = 0;
    ovr_hi        = 0;
    nl            = 0;
    mstart        = '0;
    exp_ovr       = 1'b0;
    log_last      = '0;
    reset         = 1'b1;
    frame_start   = 1'b0;
    line_start    = 1'b0;
    start_address = '0;
    cell_ready    = 1'b1;
    @(negedge clock);
    chk_zero("reset");
    tick(3);
    reset = 1'b0;
    tick(2);

    // line 0 from address 0
    log_reset();
    seen.delete();
    pulse(1, 0, 13'h0000, 0);
    pulse(0, 1, 13'h0000, 0);
    wait_drain("t1");
    chk("t1_count", 32'(seen.size()), 80);
    chk("t1_first", seen_at(0), 32'({8'h5A, 8'h8C, 4'd0, 1'b0}));
    lasts = 0;
    foreach (seen[i]) if (seen[i].last) lasts++;
    chk("t1_lasts", 32'(lasts), 1);
    chk("t1_last79", seen.size() == 80 ? 32'(seen[79].last) : 0, 1);
    chk("t1_addr_end", 32'(video_address), 79);
    chk("t1_addr_chg", 32'(addr_log.size()), 79);

    // stall: only FIFO_DEPTH reads may be outstanding
    cell_ready = 1'b0;
    log_reset();
    seen.delete();
    pulse(0, 1, 13'h0000, 0);
    chk("t2_valid_early", 32'(cell_valid), 0);
    tick(30);
    chk("t2_reads", 32'(addr_log.size()), 4);
    chk("t2_addr", 32'(video_address), 3);
    chk("t2_valid", 32'(cell_valid), 1);
    cell_ready = 1'b1;
    wait_drain("t2");
    chk("t2_count", 32'(seen.size()), 80);
    chk("t2_reads_all", 32'(addr_log.size()), 80);
    chk("t2_first", seen_at(0), 32'({8'h5A, 8'h8C, 4'd1, 1'b0}));

    // overrun 10 cycles after line 2 starts
    pulse(0, 1, 13'h0000, 0);
    tick(8);
    pulse(0, 1, 13'h0000, 1);
    seen.delete();
    wait_drain("t3");
    chk("t3_pulses", 32'(ovr_hi), 1);
    chk("t3_count", 32'(seen.size()), 80);
    chk("t3_first", seen_at(0), 32'({8'h5A, 8'h8C, 4'd3, 1'b0}));

    // address wrap at 8192
    pulse(1, 0, 13'h1FF0, 0);
    for (int l = 0; l < 16; l++) begin
      pulse(0, 1, 13'h0000, 0);
      wait_drain("t4_pre");
    end
    log_reset();
    seen.delete();
    pulse(0, 1, 13'h0000, 0);
    wait_drain("t4");
    chk("t4_addr_first", addr_log.size() > 0 ? 32'(addr_log[0]) : 0,
        32'h040);
    chk("t4_addr_last", log_tail(), 32'h08F);
    chk("t4_reads", 32'(addr_log.size()), 80);
    chk("t4_first", seen_at(0), 32'({8'h1A, 8'h8C, 4'd0, 1'b0}));

    // full frame, then DONE, then combined restart
    pulse(1, 0, 13'h0123, 0);
    for (int l = 0; l < 400; l++) begin
      pulse(0, 1, 13'h0000, 0);
      wait_drain("t5_line");
    end
    log_reset();
    seen.delete();
    pulse(0, 1, 13'h0000, 0);
    tick(200);
    chk("t5_done_cells", 32'(seen.size()), 0);
    chk("t5_done_reads", 32'(addr_log.size()), 0);
    chk("t5_done_addr", 32'(video_address), 32'h8F2);
    pulse(1, 1, 13'h0123, 0);
    wait_drain("t5_refetch");
    chk("t5_count", 32'(seen.size()), 80);
    chk("t5_first", seen_at(0), 32'({8'h79, 8'h8D, 4'd0, 1'b0}));

    // reset in the middle of a fetch
    pulse(0, 1, 13'h0000, 0);
    tick(6);
    reset = 1'b1;
    exp_q.delete();
    nl     = 0;
    mstart = '0;
    @(negedge clock);
    chk_zero("t6_reset");
    tick(2);
    reset = 1'b0;
    seen.delete();
    tick(20);
    chk("t6_quiet", 32'(seen.size()), 0);
    chk("t6_valid", 32'(cell_valid), 0);
    pulse(1, 1, 13'h0000, 0);
    wait_drain("t6");
    chk("t6_count", 32'(seen.size()), 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
